// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Full-adder slice composed of two half_adder cells and an OR on the carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p_s;
  logic g0_s;
  logic g1_s;

  half_adder u_ha_ab (
    .a (a),
    .b (b),
    .s (p_s),
    .c (g0_s)
  );

  half_adder u_ha_cin (
    .a (p_s),
    .b (cin),
    .s (s),
    .c (g1_s)
  );

  assign cout = g0_s | g1_s;

endmodule

// File: rtl/half_adder.sv
// Existing half-adder cell: sum and carry of two single bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands captured on start, added LSB-first one bit per clock
// through a single full_adder slice with a registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             load_s;
  logic             last_s;
  logic             bit_sum_s;
  logic             bit_carry_s;
  logic [WIDTH:0]   sum_shift_s;

  full_adder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (bit_sum_s),
    .cout (bit_carry_s)
  );

  assign load_s      = (state_r == IDLE) && start;
  assign last_s      = (cnt_r == LAST);
  // New bit enters at the MSB; works down to WIDTH=1 without a zero-width slice.
  assign sum_shift_s = {bit_sum_s, sum_r};

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shift registers, carry, bit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
    end else if (state_r == RUN) begin
      a_sh_r  <= a_sh_r >> 1'b1;
      b_sh_r  <= b_sh_r >> 1'b1;
      sum_r   <= sum_shift_s[WIDTH:1];
      cnt_r   <= cnt_r + CNT_W'(1);
      carry_r <= bit_carry_s;
      if (last_s) begin
        cout_r <= bit_carry_s;
      end
    end
  end

  assign busy = (state_r != IDLE);
  assign done = (state_r == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
